bitwise_pipe: RTL and testbench
===============================

# bitwise_pipe

Registered, parametrised bitwise logic unit with valid/ready handshake on both sides, an internal accumulator, and result flags (zero, parity, population count). It generalises the combinational AND/OR/XOR block to WIDTH-bit operands, an opcode-selected operation, and stateful accumulate modes. It sits between an operand producer and a result consumer, and either side may stall.

## Interface
- `WIDTH`, default 8: operand/result width, ≥ 1.
- `CNT_W`, default `$clog2(WIDTH+1)`: popcount width (derived, not overridden).

Ports:
- `clk`  in  1  rising-edge clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand/opcode present.
- `in_ready`  out  1  unit accepts the operand this cycle.
- `in_op`  in  3  opcode (`op_t`).
- `in_a`  in  WIDTH  operand A.
- `in_b`  in  WIDTH  operand B; ignored by accumulator opcodes.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  WIDTH  result.
- `out_zero`  out  1  `out_data == 0`.
- `out_parity`  out  1  XOR-reduction of `out_data`.
- `out_popcnt`  out  CNT_W  number of ones in `out_data`.

## Operation
Opcodes (`op_t`):
- 0 `OP_AND` = a & b
- 1 `OP_OR` = a | b
- 2 `OP_XOR` = a ^ b
- 3 `OP_ANDN` = a & ~b
- 4 `OP_LOAD`: acc ← a; result = a
- 5 `OP_ACC_AND`: acc ← acc & a; result = new acc
- 6 `OP_ACC_OR`: acc ← acc | a; result = new acc
- 7 `OP_ACC_XOR`: acc ← acc ^ a; result = new acc

Rules:
- Accept = `in_valid && in_ready`.
- On accept, the result and flags are computed from the inputs and the current `acc`, then registered into the output stage.
- `acc` (WIDTH bits) updates only on an accepted accumulator opcode (4–7). Opcodes 0–3 never touch `acc`.
- Flags are computed from the result being registered and registered with it. They always describe the current `out_data`.
- All arithmetic is bitwise at WIDTH bits; no carries. `out_popcnt` ranges 0..WIDTH.
- No state machine beyond the one-entry output register (EMPTY when `out_valid=0`, FULL when `out_valid=1`):
  - EMPTY → FULL on accept.
  - FULL → FULL on accept with `out_ready` (result replaced).
  - FULL → EMPTY on `out_ready` with no accept.
  - FULL holds on `!out_ready`.

## Timing
- Latency 1: an operand accepted at edge N appears with `out_valid=1` after edge N.
- `in_ready = !out_valid || out_ready` (combinational). Full throughput of one op per cycle while `out_ready=1`.
- While `out_valid && !out_ready`: `out_data`, all flags, and `acc` stay stable, and `in_ready=0`.
- `in_*` are ignored when `in_valid=0` or `in_ready=0`. A held `in_valid` with no accept has no side effect.
- Back-to-back accumulator ops: the second op sees `acc` as updated by the first. No bypass hazard, since `acc` is updated at the accept edge.
- Reset, with priority over everything including mid-transfer:
  - `out_valid=0`, `out_data=0`, `out_zero=0`, `out_parity=0`, `out_popcnt=0`, `acc=0`.
  - A pending result is discarded.
  - `in_ready=1` in the first cycle after reset deasserts.
- Simultaneous accept and output drain in the same cycle: the new result is loaded and `out_valid` stays 1.

## Structure
- Package `bitwise_pkg` holds:
  - `op_t` (3-bit enum with the eight opcodes above);
  - a `popcount` function parametrised by width.
- Sub-module `bitwise_core`: purely combinational. Inputs `op`, `a`, `b`, `acc`; outputs `result`, `acc_next`, `acc_we`.
- The top level `bitwise_pipe` owns `acc`, the output register, the flag registers and the handshake.

## Test plan
All scenarios use WIDTH=8.
1. Logic ops, `out_ready=1`: a=0xC3, b=0x5A for ops 0..3 → out 0x42, 0xDB, 0x99, 0x81, each one cycle after accept. The 0x99 result shows parity=0, popcnt=4.
2. Accumulate: LOAD 0xF0, ACC_XOR 0x0F, ACC_AND 0x3C, ACC_OR 0x01 back-to-back → out 0xF0, 0xFF, 0x3C, 0x3D.
3. Zero flag: AND a=0xAA, b=0x55 → out_data=0x00, zero=1, parity=0, popcnt=0. Then OR a=0xFF, b=0 → popcnt=8, zero=0.
4. Backpressure: hold `out_ready=0` for 5 cycles after one result → `in_ready=0`, output and `acc` frozen, a presented operand is not consumed. Release → the held result transfers, then the queued operand is accepted the same cycle.
5. Reset mid-operation: LOAD 0x77, then assert `rst` while `out_valid=1` → all outputs 0. Then ACC_OR 0x01 → out 0x01, which proves `acc` was cleared.
6. Random stream with random `in_valid`/`out_ready` against a reference model: no dropped or duplicated results, order preserved, flags consistent with `out_data`.

Source files
------------

// File: rtl/bitwise_pkg.sv
// Shared types and helpers for the bitwise pipeline: opcode encoding and popcount.
package bitwise_pkg;

  typedef enum logic [2:0] {
    OP_AND     = 3'd0,
    OP_OR      = 3'd1,
    OP_XOR     = 3'd2,
    OP_ANDN    = 3'd3,
    OP_LOAD    = 3'd4,
    OP_ACC_AND = 3'd5,
    OP_ACC_OR  = 3'd6,
    OP_ACC_XOR = 3'd7
  } op_t;

  // Widest operand the popcount helper handles; callers zero-extend into it.
  localparam int unsigned POP_MAX_W = 256;

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < POP_MAX_W; i++) begin
      cnt += 32'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/bitwise_core.sv
// Combinational datapath: opcode-selected result and accumulator next value.
module bitwise_core
  import bitwise_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] acc_next,
  output logic             acc_we
);

  always_comb begin
    result   = '0;
    acc_next = acc;
    acc_we   = 1'b0;
    case (op)
      OP_AND:     result = a & b;
      OP_OR:      result = a | b;
      OP_XOR:     result = a ^ b;
      OP_ANDN:    result = a & ~b;
      OP_LOAD:    begin acc_next = a;       acc_we = 1'b1; result = acc_next; end
      OP_ACC_AND: begin acc_next = acc & a; acc_we = 1'b1; result = acc_next; end
      OP_ACC_OR:  begin acc_next = acc | a; acc_we = 1'b1; result = acc_next; end
      OP_ACC_XOR: begin acc_next = acc ^ a; acc_we = 1'b1; result = acc_next; end
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/bitwise_pipe.sv
// Registered bitwise logic unit with accumulator, result flags and a
// one-entry valid/ready output stage.
module bitwise_pipe
  import bitwise_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  op_t              in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_popcnt
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] result_c;
  logic [WIDTH-1:0] acc_next_c;
  logic             acc_we_c;
  logic             accept_c;

  bitwise_core #(.WIDTH(WIDTH)) u_core (
    .op       (in_op),
    .a        (in_a),
    .b        (in_b),
    .acc      (acc),
    .result   (result_c),
    .acc_next (acc_next_c),
    .acc_we   (acc_we_c)
  );

  // The output slot can take a new result when empty or draining this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept_c = in_valid && in_ready;

  // Output stage, flags and accumulator all move together on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_zero   <= 1'b0;
      out_parity <= 1'b0;
      out_popcnt <= '0;
      acc        <= '0;
    end else if (accept_c) begin
      out_valid  <= 1'b1;
      out_data   <= result_c;
      out_zero   <= (result_c == '0);
      out_parity <= ^result_c;
      out_popcnt <= CNT_W'(popcount(POP_MAX_W'(result_c)));
      if (acc_we_c) begin
        acc <= acc_next_c;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bitwise_pipe.sv
// Directed + random bench for bitwise_pipe with a scoreboard of expected results.
module tb_bitwise_pipe;
  import bitwise_pkg::*;

  localparam int unsigned W = 8;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  op_t           in_op;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_zero;
  logic          out_parity;
  logic [CW-1:0] out_popcnt;

  bitwise_pipe #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_zero   (out_zero),
    .out_parity (out_parity),
    .out_popcnt (out_popcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  d;
    logic          z;
    logic          p;
    logic [CW-1:0] c;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] m_acc;
  logic         m_full;
  int           vectors;
  int           miscompares;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model of one accepted operation.
  task automatic model_push(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    exp_t e;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = a & ~b;
      3'd4: r = a;
      3'd5: r = m_acc & a;
      3'd6: r = m_acc | a;
      default: r = m_acc ^ a;
    endcase
    if (op >= 3'd4) m_acc = r;
    e.d = r;
    e.z = (r == 8'h00);
    e.p = ^r;
    e.c = CW'($countones(r));
    sb.push_back(e);
  endtask

  // One clock cycle: drive at negedge, check outputs, then update the model.
  task automatic cyc(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic rdy);
    logic exp_rdy;
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    in_op     = op_t'(op);
    in_a      = a;
    in_b      = b;
    out_ready = rdy;
    #1;
    exp_rdy = !m_full || rdy;
    chk("out_valid", 32'(out_valid), 32'(m_full));
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (m_full && rdy) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'(1), 32'(0));
      end else begin
        e = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(e.d));
        chk("out_zero", 32'(out_zero), 32'(e.z));
        chk("out_parity", 32'(out_parity), 32'(e.p));
        chk("out_popcnt", 32'(out_popcnt), 32'(e.c));
      end
    end
    if (v && exp_rdy) begin
      model_push(op, a, b);
      m_full = 1'b1;
    end else if (rdy) begin
      m_full = 1'b0;
    end
  endtask

  // Reset while keeping an operand presented, to show reset takes priority.
  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_op     = OP_LOAD;
    in_a      = 8'hEE;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(0));
    chk("rst_out_zero", 32'(out_zero), 32'(0));
    chk("rst_out_parity", 32'(out_parity), 32'(0));
    chk("rst_out_popcnt", 32'(out_popcnt), 32'(0));
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    m_acc  = '0;
    m_full = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_acc       = '0;
    m_full      = 1'b0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_op       = OP_AND;
    in_a        = '0;
    in_b        = '0;
    out_ready   = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    // Logic ops streamed at full throughput.
    cyc(1, 3'd0, 8'hC3, 8'h5A, 1);
    cyc(1, 3'd1, 8'hC3, 8'h5A, 1);
    cyc(1, 3'd2, 8'hC3, 8'h5A, 1);
    cyc(1, 3'd3, 8'hC3, 8'h5A, 1);
    cyc(0, 3'd0, 8'h00, 8'h00, 1);

    // Accumulator chain back-to-back.
    cyc(1, 3'd4, 8'hF0, 8'hAA, 1);
    cyc(1, 3'd7, 8'h0F, 8'hAA, 1);
    cyc(1, 3'd5, 8'h3C, 8'hAA, 1);
    cyc(1, 3'd6, 8'h01, 8'hAA, 1);
    cyc(0, 3'd0, 8'h00, 8'h00, 1);

    // Zero and full-ones flags.
    cyc(1, 3'd0, 8'hAA, 8'h55, 1);
    cyc(1, 3'd1, 8'hFF, 8'h00, 1);
    cyc(0, 3'd0, 8'h00, 8'h00, 1);

    // Backpressure: result held, presented ACC_XOR must not be consumed.
    cyc(1, 3'd4, 8'h11, 8'h00, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 3'd7, 8'h02, 8'h00, 0);
      chk("hold_out_data", 32'(out_data), 32'(8'h11));
    end
    cyc(1, 3'd7, 8'h02, 8'h00, 1);
    cyc(0, 3'd0, 8'h00, 8'h00, 1);

    // Reset with a pending result, then prove acc was cleared.
    cyc(1, 3'd4, 8'h77, 8'h00, 0);
    cyc(0, 3'd0, 8'h00, 8'h00, 0);
    do_reset();
    cyc(1, 3'd6, 8'h01, 8'h00, 1);
    cyc(0, 3'd0, 8'h00, 8'h00, 1);

    // Random stream with random handshakes.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
          8'($urandom), 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 20 && (sb.size() != 0 || m_full); i++) begin
      cyc(0, 3'd0, 8'h00, 8'h00, 1);
    end
    chk("drain_empty", 32'(sb.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
